clkdiv_ctrl: RTL

Run-control and ratio scheduler for the slow-clock path. Produces a divided square wave `slower_clk` from `clk` and starts and stops it only at period boundaries. It accepts new divide ratios through a valid/ready handshake and applies them glitch-free at the end of the current period. It sits between the configuration logic and every consumer of the slow clock or its `tick` strobe.

---
 rtl/clkdiv_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/clkdiv_ctrl.sv
// Run-control and ratio scheduler: divides clk into slower_clk and changes ratio or run state only at period boundaries.
// Optional burst mode (fixed number of slow periods per run) is enabled by defining CLKDIV_CTRL_BURST_EN.
module clkdiv_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             slower_clk,
  output logic             tick,
`ifdef CLKDIV_CTRL_BURST_EN
  input  logic [7:0]       burst_len,
  output logic             burst_done,
`endif
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] cnt, div_q, pend_q, cfg_clamped;
  logic             pend_v, clk_q, tick_q;
  logic             accept, at_toggle, boundary, armed, burst_hit;

  // Handshake: a ratio transfers on any edge where cfg_valid && cfg_ready;
  // cfg_ready is low exactly while a ratio waits in the pending slot.
  assign accept      = cfg_valid & ~pend_v;
  assign cfg_clamped = (cfg_div == '0) ? WIDTH'(1) : cfg_div;
  assign at_toggle   = (cnt == div_q - WIDTH'(1));
  assign boundary    = (state == RUN) & ~clk_q & at_toggle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (enable && armed) state_d = RUN;
      RUN:     if (boundary && (!enable || burst_hit)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == RUN);
    cfg_ready  = ~pend_v;
    slower_clk = clk_q;
    tick       = tick_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      div_q  <= WIDTH'(DEFAULT_DIV);
      pend_q <= '0;
      pend_v <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (state == IDLE) begin
        // Ratios offered while stopped bypass the pending slot.
        cnt <= '0;
        if (accept) div_q <= cfg_clamped;
        clk_q  <= (state_d == RUN);
        tick_q <= (state_d == RUN);
      end else begin
        if (accept) begin
          pend_q <= cfg_clamped;
          pend_v <= 1'b1;
        end
        if (at_toggle) begin
          cnt <= '0;
          if (clk_q) begin
            clk_q <= 1'b0;
          end else begin
            if (pend_v) begin
              div_q  <= pend_q;
              pend_v <= 1'b0;
            end
            if (state_d == RUN) begin
              clk_q  <= 1'b1;
              tick_q <= 1'b1;
            end
          end
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end
    end
  end

`ifdef CLKDIV_CTRL_BURST_EN
  logic [7:0] burst_q, rise_cnt;
  logic       armed_q, done_q;

  // rise_cnt counts slow rising edges of the current run, including the start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_q  <= 8'd0;
      rise_cnt <= 8'd0;
      armed_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (!enable) armed_q <= 1'b1;
        if (state_d == RUN) begin
          burst_q  <= burst_len;
          rise_cnt <= 8'd1;
        end
      end else if (boundary) begin
        if (burst_hit) begin
          done_q  <= 1'b1;
          armed_q <= 1'b0;
        end else if (state_d == RUN) begin
          rise_cnt <= rise_cnt + 8'd1;
        end
      end
    end
  end

  assign armed      = armed_q;
  assign burst_hit  = (burst_q != 8'd0) && (rise_cnt >= burst_q);
  assign burst_done = done_q;
`else
  assign armed     = 1'b1;
  assign burst_hit = 1'b0;
`endif

endmodule
